// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the Galois LFSR burst generator.
//   fsm_e      - controller states (IDLE / BURST)
//   DEF_POLY   - default 6-bit tap mask (x^6 + x + 1, maximal length)
//   lfsr_next  - one Galois advance of a w-bit register
package lfsr_pkg;

  typedef enum logic {S_IDLE, S_BURST} fsm_e;

  localparam logic [5:0] DEF_POLY = 6'b000010;

  // Widest register the helper function supports.
  localparam int MAX_W = 32;

  // Galois step: the MSB is shifted out and fed back into bit 0 and into
  // every bit whose tap is set. Only the low w bits are meaningful.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] q,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               w);
    logic             fb;
    logic [MAX_W-1:0] n;
    fb   = q[w-1];
    n    = '0;
    n[0] = fb;
    for (int i = 1; i < MAX_W; i++)
      if (i < w) n[i] = q[i-1] ^ (poly[i] & fb);
    return n;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: Galois LFSR with seed load, counted bursts, free-run advance
// and period measurement back to the stored seed.
//   clk, rst             - clock (rising edge), async active-high reset
//   load, seed           - load seed (zero seed is replaced by 1)
//   start, n_steps       - run a burst of n_steps advances
//   enable               - free-run advance while idle
//   state_out            - current LFSR state
//   busy / done          - burst in progress / one-cycle completion pulse
//   wrap, period_out     - pulse when state returns to seed, and that period
//   lockup               - pulse when a zero seed was replaced
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 6,      // at least 3, at most MAX_W
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             enable,
  output logic [WIDTH-1:0] state_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [WIDTH-1:0] period_out,
  output logic             lockup
);

  fsm_e             r_fsm;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_cnt;
  logic [CNT_W-1:0] r_rem;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed_fix;
  logic             w_adv;

  assign w_next     = WIDTH'(lfsr_next(MAX_W'(state_out), MAX_W'(POLY), WIDTH));
  // An all-zero state is a fixed point of the LFSR, so it is never loaded.
  assign w_seed_fix = (seed == '0) ? WIDTH'(1) : seed;

  // One advance per cycle: every BURST cycle, or enable while idle with no
  // higher-priority request pending.
  assign w_adv = !load &&
                 ((r_fsm == S_BURST) || (!start && enable));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_seed     <= WIDTH'(1);
      r_cnt      <= '0;
      r_rem      <= '0;
      state_out  <= WIDTH'(1);
      period_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
      lockup     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wrap   <= 1'b0;
      lockup <= 1'b0;

      if (load) begin
        // Load aborts a burst silently: no done pulse.
        state_out <= w_seed_fix;
        r_seed    <= w_seed_fix;
        r_cnt     <= '0;
        r_rem     <= '0;
        r_fsm     <= S_IDLE;
        busy      <= 1'b0;
        lockup    <= (seed == '0);
      end else begin
        if (w_adv) begin
          state_out <= w_next;
          if (w_next == r_seed) begin
            period_out <= r_cnt + 1'b1;
            r_cnt      <= '0;
            wrap       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        case (r_fsm)
          S_IDLE: begin
            // Acceptance cycle only latches the count; advancing starts next.
            if (start) begin
              if (n_steps != '0) begin
                r_fsm <= S_BURST;
                r_rem <= n_steps;
                busy  <= 1'b1;
              end else begin
                done  <= 1'b1;
              end
            end
          end
          S_BURST: begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) begin
              r_fsm <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: r_fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 6, register width in bits; SHALL be at least 3.
REQ-002 Parameter POLY, default 6'b000010, Galois tap mask; bit i set means feedback enters bit i, bit 0 always takes feedback.
REQ-003 Parameter CNT_W, default 8, width of the burst step count.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 load  in  1  load seed into register, highest priority.
REQ-007 seed  in  WIDTH  seed value sampled on load.
REQ-008 start  in  1  begin a burst of n_steps advances.
REQ-009 n_steps  in  CNT_W  burst length, sampled on accepted start.
REQ-010 enable  in  1  free-run advance, one step per cycle, IDLE only.
REQ-011 state_out  out  WIDTH  current LFSR state, registered.
REQ-012 busy  out  1  high while FSM is in BURST.
REQ-013 done  out  1  one-cycle pulse when a burst completes.
REQ-014 wrap  out  1  one-cycle pulse when an advance returns the state to the stored seed.
REQ-015 period_out  out  WIDTH  step count of the last completed cycle back to the seed.
REQ-016 lockup  out  1  one-cycle pulse when a zero seed was replaced.

Function
REQ-017 Advance SHALL compute next[0]=q[W-1] and next[i]=q[i-1]^(POLY[i]&q[W-1]) for i>=1.
REQ-018 FSM states SHALL be IDLE and BURST only.
REQ-019 Input priority per cycle SHALL be: load, then start, then enable.
REQ-020 On load, in any state, state_out and seed_reg SHALL take seed; the step counter SHALL clear; the FSM SHALL go to IDLE and abort any burst without a done pulse.
REQ-021 A load with seed==0 SHALL load 1 instead and pulse lockup in the next cycle.
REQ-022 start in IDLE with n_steps>0 SHALL go to BURST with remaining count n_steps; no advance SHALL occur in the acceptance cycle.
REQ-023 In BURST, each cycle SHALL advance once and decrement the remaining count; the cycle that advances with remaining count 1 SHALL return the FSM to IDLE.
REQ-024 done SHALL go high in the cycle after the final burst advance, for exactly one cycle.
REQ-025 start in IDLE with n_steps==0 SHALL pulse done in the next cycle, with no advance and busy staying low.
REQ-026 start during BURST SHALL be ignored; enable during BURST SHALL have no additional effect.
REQ-027 enable in IDLE, with no load or start, SHALL advance once per cycle.
REQ-028 Every advance SHALL increment the step counter; when the advanced value equals seed_reg, period_out SHALL become counter+1, the counter SHALL clear, and wrap SHALL pulse in the cycle the new state appears.
REQ-029 The step counter SHALL be WIDTH bits wide and SHALL not saturate, since the maximal period is 2^WIDTH-1.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst is high: state_out and seed_reg SHALL be 1; counter, period_out and remaining count SHALL be 0; FSM SHALL be IDLE; busy, done, wrap and lockup SHALL be 0.
REQ-032 Reset during BURST SHALL abort immediately, with no done pulse after release.
REQ-033 The first advance SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-034 Package lfsr_pkg SHALL hold the FSM state enum, the default POLY constant, and the pure function lfsr_next(q, poly) implementing REQ-017.
REQ-035 No sub-module SHALL be used; the next-state logic SHALL be the package function.

Verification (WIDTH=6, POLY=6'b000010)
REQ-036 Case 1: reset, then idle -> state_out=6'h01, busy=0, done=0, period_out=0.
REQ-037 Case 2: load seed=6'h01, start n_steps=6 -> busy high for 6 cycles; states 02,04,08,10,20,03; done pulses once; state_out holds 6'h03.
REQ-038 Case 3: load seed=6'h01, enable held for 63 cycles -> wrap pulses on the 63rd advance with state_out=6'h01 and period_out=63; no earlier wrap.
REQ-039 Case 4: load seed=6'h00 -> state_out=6'h01 and lockup pulses for one cycle.
REQ-040 Case 5: start n_steps=10, load seed=6'h05 on the 3rd BURST cycle -> state_out=6'h05, busy=0, no done pulse; start n_steps=0 -> done in the next cycle, state unchanged.
REQ-041 Case 6: assert rst mid-burst -> outputs match REQ-031 asynchronously; no done pulse after release.
